// File: rtl/fantasticfft_fft8_serializer.sv
// Output-side consumer of the 8-point FFT. Captures each parallel result
// frame into a two-slot ring buffer and streams it out one bin per cycle
// over a valid/ready handshake. When the buffer is full and the downstream
// does not pop, an incoming frame is dropped and counted.
module fantasticfft_fft8_serializer #(
    parameter int INT_SIZE  = 8,
    parameter int FRAC_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y0,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y1,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y2,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y3,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y4,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y5,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y6,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y7,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y0_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y1_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y2_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y3_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y4_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y5_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y6_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y7_i,
    input  logic                          resultValid,
    output logic [INT_SIZE+FRAC_SIZE-1:0] out_re,
    output logic [INT_SIZE+FRAC_SIZE-1:0] out_im,
    output logic [2:0]                    out_bin,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          clear_ovf,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int W = INT_SIZE + FRAC_SIZE;

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    fill_t        r_fill;
    fill_t        w_fill_next;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [2:0]   r_bin_idx;
    logic         r_overflow;
    logic [7:0]   r_drop_count;

    logic [W-1:0] r_mem_re [0:1][0:7];
    logic [W-1:0] r_mem_im [0:1][0:7];

    logic [W-1:0] w_in_re [0:7];
    logic [W-1:0] w_in_im [0:7];

    logic         w_out_valid;
    logic         w_xfer;
    logic         w_pop;
    logic         w_capture;
    logic         w_drop;
    logic [7:0]   w_count_base;
    logic [7:0]   w_count_next;
    logic         w_overflow_next;

    assign w_in_re = '{y0, y1, y2, y3, y4, y5, y6, y7};
    assign w_in_im = '{y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i};

    assign w_out_valid = (r_fill != EMPTY);
    assign w_xfer      = w_out_valid && out_ready;
    assign w_pop       = w_xfer && (r_bin_idx == 3'd7);
    // A pop frees the slot being read in the same cycle, so a frame arriving
    // while FULL is still accepted if bin 7 leaves at the same edge.
    assign w_capture   = resultValid && ((r_fill != FULL) || w_pop);
    assign w_drop      = resultValid && (r_fill == FULL) && !w_pop;

    // Frame slot storage; no reset needed since occupancy gates visibility.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bin
            always_ff @(posedge clk) begin
                if (w_capture) begin
                    r_mem_re[r_wr_ptr][gi] <= w_in_re[gi];
                    r_mem_im[r_wr_ptr][gi] <= w_in_im[gi];
                end
            end
        end
    endgenerate

    // Next occupancy from the capture/pop combination.
    always_comb begin
        w_fill_next = r_fill;
        case (r_fill)
            EMPTY: if (w_capture) w_fill_next = ONE;
            ONE: begin
                if (w_capture && !w_pop)      w_fill_next = FULL;
                else if (!w_capture && w_pop) w_fill_next = EMPTY;
            end
            FULL:  if (w_pop && !w_capture) w_fill_next = ONE;
            default: w_fill_next = EMPTY;
        endcase
    end

    // Clear is applied first so a same-cycle drop still registers as one.
    always_comb begin
        w_count_base    = clear_ovf ? 8'd0 : r_drop_count;
        w_count_next    = w_count_base;
        w_overflow_next = clear_ovf ? 1'b0 : r_overflow;
        if (w_drop) begin
            w_overflow_next = 1'b1;
            if (w_count_base != 8'hFF) w_count_next = w_count_base + 8'd1;
        end
    end

    // Occupancy, ring pointers, bin index and drop statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill       <= EMPTY;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_bin_idx    <= 3'd0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_fill       <= w_fill_next;
            r_overflow   <= w_overflow_next;
            r_drop_count <= w_count_next;
            if (w_capture) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)     r_rd_ptr <= ~r_rd_ptr;
            if (w_xfer)    r_bin_idx <= r_bin_idx + 3'd1;
        end
    end

    // Output mux; everything reads zero while the buffer is empty.
    always_comb begin
        out_re  = '0;
        out_im  = '0;
        out_bin = 3'd0;
        if (w_out_valid) begin
            out_re  = r_mem_re[r_rd_ptr][r_bin_idx];
            out_im  = r_mem_im[r_rd_ptr][r_bin_idx];
            out_bin = r_bin_idx;
        end
    end

    assign out_valid  = w_out_valid;
    assign out_last   = w_out_valid && (r_bin_idx == 3'd7);
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_fantasticfft_fft8_serializer.sv
// Scoreboard bench for the FFT8 output serializer: stimulus pushes expected
// bins into a queue, a negedge monitor pops and compares on each transfer.
module tb_fantasticfft_fft8_serializer;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  bin;
        logic        last;
    } bin_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] y_re [0:7];
    logic [15:0] y_im [0:7];
    logic        result_valid = 1'b0;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [2:0]  out_bin;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        overflow;
    logic [7:0]  drop_count;

    bin_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fantasticfft_fft8_serializer #(.INT_SIZE(8), .FRAC_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .y0(y_re[0]), .y1(y_re[1]), .y2(y_re[2]), .y3(y_re[3]),
        .y4(y_re[4]), .y5(y_re[5]), .y6(y_re[6]), .y7(y_re[7]),
        .y0_i(y_im[0]), .y1_i(y_im[1]), .y2_i(y_im[2]), .y3_i(y_im[3]),
        .y4_i(y_im[4]), .y5_i(y_im[5]), .y6_i(y_im[6]), .y7_i(y_im[7]),
        .resultValid(result_valid),
        .out_re(out_re), .out_im(out_im), .out_bin(out_bin),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .clear_ovf(clear_ovf), .overflow(overflow), .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Present one frame for one cycle; push its bins if it should be kept.
    task automatic send_frame(input logic [7:0] tag, input bit keep);
        for (int k = 0; k < 8; k++) begin
            y_re[k] = 16'((k + 1) << 8) | {8'h00, tag};
            y_im[k] = 16'(16'hFF00 - (k << 8)) | {8'h00, tag};
        end
        result_valid = 1'b1;
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        if (keep) begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back('{re: y_re[k], im: y_im[k], bin: 3'(k), last: (k == 7)});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted bin must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            bin_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer actual bin=%0d re=0x%0h required=none", out_bin, out_re);
            end else begin
                e = exp_q.pop_front();
                $display("xfer bin=%0d re=0x%04h im=0x%04h last=%0d", out_bin, out_re, out_im, out_last);
                chk("xfer_re", 32'(out_re), 32'(e.re));
                chk("xfer_im", 32'(out_im), 32'(e.im));
                chk("xfer_bin", 32'(out_bin), 32'(e.bin));
                chk("xfer_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic chk_idle(input string name);
        chk({name, "_qempty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_valid0"}, 32'(out_valid), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_last"}, 32'(out_last), 32'd0);
        chk({name, "_re"}, 32'(out_re), 32'd0);
        chk({name, "_im"}, 32'(out_im), 32'd0);
        chk({name, "_bin"}, 32'(out_bin), 32'd0);
        chk({name, "_ovf"}, 32'(overflow), 32'd0);
        chk({name, "_cnt"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            y_re[k] = 16'h0;
            y_im[k] = 16'h0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        cycles(1);

        // Single frame, latency 1, eight bins back to back
        out_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        chk("single_lat_valid", 32'(out_valid), 32'd1);
        chk("single_lat_bin", 32'(out_bin), 32'd0);
        cycles(8);
        chk_idle("single");

        // Backpressure: bin 0 held for five cycles, then streams
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_bin", 32'(out_bin), 32'd0);
            chk("bp_re", 32'(out_re), 32'h0111);
            chk("bp_im", 32'(out_im), 32'hFF11);
            chk("bp_last", 32'(out_last), 32'd0);
            if (i < 4) cycles(1);
        end
        cycles(1);
        out_ready = 1'b1;
        cycles(8);
        chk_idle("bp");

        // Burst of three: A and B kept, C dropped; drain with no bubble
        out_ready = 1'b0;
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b0);
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_cnt", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("burst_nobubble", 32'(out_valid), 32'd1);
            cycles(1);
        end
        chk_idle("burst");
        clear_ovf = 1'b1;
        cycles(1);
        clear_ovf = 1'b0;
        chk("clr1_ovf", 32'(overflow), 32'd0);
        chk("clr1_cnt", 32'(drop_count), 32'd0);

        // Pop/capture collision while FULL
        out_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        send_frame(8'h66, 1'b1);
        out_ready = 1'b1;
        cycles(7);
        chk("coll_bin7", 32'(out_bin), 32'd7);
        send_frame(8'h77, 1'b1);
        out_ready = 1'b0;
        chk("coll_cnt", 32'(drop_count), 32'd0);
        chk("coll_ovf", 32'(overflow), 32'd0);
        send_frame(8'h88, 1'b0);
        chk("coll_full_cnt", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        cycles(16);
        chk_idle("coll");
        clear_ovf = 1'b1;
        cycles(1);
        clear_ovf = 1'b0;

        // Saturation, clear alone, clear with same-cycle drop
        out_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        send_frame(8'hAA, 1'b1);
        for (int i = 0; i < 300; i++) send_frame(8'hBB, 1'b0);
        chk("sat_cnt", 32'(drop_count), 32'd255);
        chk("sat_ovf", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        cycles(1);
        clear_ovf = 1'b0;
        chk("clr2_ovf", 32'(overflow), 32'd0);
        chk("clr2_cnt", 32'(drop_count), 32'd0);
        clear_ovf = 1'b1;
        send_frame(8'hCC, 1'b0);
        clear_ovf = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 32'd1);
        chk("clrdrop_cnt", 32'(drop_count), 32'd1);

        // Asynchronous reset at bin 3 with a FULL buffer
        out_ready = 1'b1;
        cycles(3);
        chk("rst_pre_bin", 32'(out_bin), 32'd3);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_zero_outputs("async_rst");
        #10;
        rst_n = 1'b1;
        cycles(1);
        send_frame(8'hDD, 1'b1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_bin", 32'(out_bin), 32'd0);
        cycles(8);
        chk_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fantasticfft_fft8_serializer.md
# fantasticfft_fft8_serializer

Consumer on the output side of the 8-point FFT. It captures each parallel result frame (eight real and eight imaginary bins, qualified by `resultValid`) into a two-frame buffer. It then streams the frame out one bin per cycle over a valid/ready handshake. The FFT has no backpressure, so this block absorbs bursts, and it drops and counts frames when the downstream stalls too long.

## Interface
- `INT_SIZE`, 8, integer bits of each signed fixed-point sample
- `FRAC_SIZE`, 8, fractional bits; W = INT_SIZE + FRAC_SIZE
- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `y0`..`y7`  in  W each  real parts of bins 0..7 (two's complement)
- `y0_i`..`y7_i`  in  W each  imaginary parts of bins 0..7
- `resultValid`  in  1  frame on `y*` is valid this cycle (single-cycle pulse per frame)
- `out_re`  out  W  real part of current bin
- `out_im`  out  W  imaginary part of current bin
- `out_bin`  out  3  index of current bin, 0..7
- `out_last`  out  1  high when `out_bin` == 7 and `out_valid`
- `out_valid`  out  1  bin presented
- `out_ready`  in  1  downstream accepts bin
- `clear_ovf`  in  1  clears `overflow` and `drop_count`
- `overflow`  out  1  sticky: at least one frame dropped
- `drop_count`  out  8  frames dropped, saturates at 255

## Operation
- Storage: two frame slots, each 16×W bits, managed as a ring.
  - `wr_ptr` and `rd_ptr` are each 1 bit.
  - `fill` is 2 bits, range 0..2.
- Occupancy state follows `fill`:
  - EMPTY (0) -> ONE on capture.
  - ONE -> FULL on capture without pop.
  - ONE -> EMPTY on pop without capture.
  - ONE -> ONE on simultaneous capture and pop.
  - FULL -> ONE on pop.
  - FULL stays FULL on pop plus capture.
- Pop: the cycle in which `out_valid && out_ready && out_bin == 7`.
- Capture condition: `resultValid && (fill < 2 || pop)`.
  - Capture writes all 16 inputs into slot `wr_ptr`, then toggles `wr_ptr`.
  - Simultaneous capture and pop while FULL is accepted, not dropped.
- Drop: `resultValid` while FULL and no pop.
  - The frame is discarded and the buffer is unchanged.
  - `overflow` <= 1.
  - `drop_count` <= min(`drop_count` + 1, 255).
- `clear_ovf` is applied first, then a same-cycle drop. Result: `overflow` = 1, `drop_count` = 1.
- Output path:
  - `out_valid` = (`fill` != 0).
  - `out_re` / `out_im` come from slot `rd_ptr`, bin `bin_idx`.
  - `out_bin` = `bin_idx`.
- Transfer is `out_valid && out_ready`.
  - `bin_idx` increments on each transfer and wraps 7 -> 0 on pop.
  - `rd_ptr` toggles on pop.
- Data passes through bit-exact. No rescaling, no sign extension. Bins 0 and 4 imaginary parts are forwarded as received.
- Output hold: while `out_valid && !out_ready`, `out_re`, `out_im`, `out_bin` and `out_last` hold stable.
- `out_valid` never deasserts without a transfer.
- When `fill` = 0: `out_re`, `out_im` and `out_bin` drive 0, and `out_last` = 0.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `fill` = 0, both pointers 0, `bin_idx` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_re` = `out_im` = 0, `out_bin` = 0.
  - `overflow` = 0, `drop_count` = 0.
  - Slot contents need not be cleared.
- Reset mid-stream discards all buffered frames and any partially streamed frame.
- Latency: `resultValid` at edge N with buffer EMPTY -> `out_valid` = 1 with bin 0 after edge N, i.e. in cycle N+1.
- Throughput: one bin per cycle with `out_ready` held high, i.e. one frame per 8 cycles.
- Sustained `resultValid` faster than 1 per 8 cycles causes drops once FULL.
- A frame captured while another streams does not disturb the streaming slot.
- Back-to-back frames stream with no bubble: bin 7 of frame A, then bin 0 of frame B on the next cycle.

## Test plan
- Single frame:
  - Stimulus: y0..y7 = 0x0100..0x0800, y_i = 0xFF00..0xF800; one `resultValid` pulse; `out_ready` = 1.
  - Response: 8 transfers in cycles N+1..N+8; bins 0..7 exactly in order; `out_last` only on bin 7; `out_valid` = 0 afterwards.
- Backpressure:
  - Stimulus: same frame; `out_ready` low for cycles N+1..N+5.
  - Response: bin 0 and its data held stable through N+5; bin 0 transfers at N+6; no data changes while stalled.
- Burst and drop:
  - Stimulus: three frames A, B, C on consecutive cycles; `out_ready` = 0.
  - Response: A and B stored; C dropped; `overflow` = 1, `drop_count` = 1. After releasing `out_ready`: 16 bins, A then B, no bubble.
- Pop/capture collision:
  - Stimulus: buffer FULL; new frame arrives on the cycle bin 7 is accepted.
  - Response: frame captured, `drop_count` unchanged, buffer still FULL with the correct ordering.
- Overflow management:
  - 300 drops -> `drop_count` saturates at 255.
  - `clear_ovf` alone -> `overflow` = 0, `drop_count` = 0.
  - `clear_ovf` plus a same-cycle drop -> `overflow` = 1, `drop_count` = 1.
- Reset:
  - Stimulus: assert `rst_n` low asynchronously mid-frame at bin 3 with FULL buffer.
  - Response: all outputs 0 immediately. After release, the next frame streams from bin 0 with latency 1.
